wb_arbiter: RTL and testbench

Writeback stage directly upstream of the 32x64 integer register file. It merges two result sources into the register file's single write port:
- the in-order pipeline (MEM stage);
- an out-of-band long-latency unit (mul/div).

It keeps a per-register busy scoreboard so that long-latency destinations are interlocked. It also exposes the registered write as a bypass source.

---
 rtl/wb_arbiter_pkg.sv | 19 +
 rtl/wb_scoreboard.sv | 66 ++++++
 rtl/wb_scoreboard_chk.sv | 13 +
 rtl/wb_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its scoreboard.
package wb_arbiter_pkg;

  localparam int XLEN       = 64;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  wen;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // True when a result targets a real architectural register (x0 is discarded).
  function automatic logic writes_reg(input logic wen, input logic [REG_ADDR_W-1:0] rd);
    return wen && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy scoreboard for long-latency destinations.
// Set (issue) wins over clear (retire) on the same register; bit 0 is always 0.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  retire_i,
  input  logic [REG_ADDR_W-1:0] retire_rd_i,
  input  logic                  lookup_wen_i,
  input  logic [REG_ADDR_W-1:0] lookup_rd_i,
  output logic                  issue_ready_o,
  output logic                  stall_o,
  output logic [NREG-1:0]       busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            issue_fire_s;

  // Issue is allowed to a free register, to x0, or to a register whose
  // outstanding result retires this very cycle (the new issue then owns it).
  always_comb begin
    issue_ready_o = (issue_rd_i == 5'd0) || !busy_q[issue_rd_i] ||
                    (retire_i && (retire_rd_i == issue_rd_i));
    stall_o       = writes_reg(lookup_wen_i, lookup_rd_i) && busy_q[lookup_rd_i];
    issue_fire_s  = issue_i && issue_ready_o;
  end

  // Next busy vector: clear on retire first, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (retire_i && (retire_rd_i != 5'd0)) begin
      busy_d[retire_rd_i] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (issue_fire_s && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

  wb_scoreboard_chk u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_i       (issue_i),
    .issue_ready_i (issue_ready_o)
  );

endmodule

// File: rtl/wb_scoreboard_chk.sv
// Protocol checker for the busy scoreboard: a long-latency op must never be
// issued to a destination that is still waiting for its previous result.
module wb_scoreboard_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic issue_i,
  input logic issue_ready_i
);

  a_no_issue_to_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_i && !issue_ready_i));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges MEM-stage and long-latency results into the single
// register-file write port, long-latency first, with a registered write.
// Optional feature macro: WB_COMMIT_TRACE_EN adds a per-instruction commit trace.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pipe_valid,
  output logic                  pipe_ready,
  input  logic                  pipe_wen,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_rd,
  output logic                  lu_issue_ready,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
`ifdef WB_COMMIT_TRACE_EN
  input  logic [63:0]           pipe_pc,
  output logic                  commit_valid,
  output logic [63:0]           commit_pc,
`endif
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NREG-1:0]       busy_vec
);

  logic                  stall_s;
  logic                  pipe_fire_s;
  logic                  lu_fire_s;
  wb_req_t               req_s;
  logic                  rf_wen_q,   rf_wen_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

  wb_scoreboard u_scoreboard (
    .clk_i         (clock),
    .rst_ni        (reset),
    .issue_i       (lu_issue),
    .issue_rd_i    (lu_issue_rd),
    .retire_i      (lu_fire_s),
    .retire_rd_i   (lu_rd),
    .lookup_wen_i  (pipe_wen),
    .lookup_rd_i   (pipe_rd),
    .issue_ready_o (lu_issue_ready),
    .stall_o       (stall_s),
    .busy_o        (busy_vec)
  );

  // Handshakes: the long-latency result is always taken; the pipe waits for it
  // and for any outstanding long-latency write to the same destination.
  always_comb begin
    lu_ready    = 1'b1;
    pipe_ready  = !lu_valid && !stall_s;
    lu_fire_s   = lu_valid;
    pipe_fire_s = pipe_valid && pipe_ready;
  end

  // Select the winning request; x0 results complete but never write.
  always_comb begin
    req_s = '{wen: 1'b0, rd: rf_waddr_q, data: rf_wdata_q};
    if (lu_fire_s) begin
      req_s = '{wen: writes_reg(1'b1, lu_rd), rd: lu_rd, data: lu_data};
    end else if (pipe_fire_s) begin
      req_s = '{wen: writes_reg(pipe_wen, pipe_rd), rd: pipe_rd, data: pipe_data};
    end else begin
      req_s.wen = 1'b0;
    end
    rf_wen_d = req_s.wen;
    if (req_s.wen) begin
      rf_waddr_d = req_s.rd;
      rf_wdata_d = req_s.data;
    end else begin
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 64'd0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_COMMIT_TRACE_EN
  logic        commit_valid_q, commit_valid_d;
  logic [63:0] commit_pc_q,    commit_pc_d;
  logic [63:0] commit_cnt_q,   commit_cnt_d;

  // Every accepted pipe instruction commits, writing or not.
  always_comb begin
    commit_valid_d = pipe_fire_s;
    if (pipe_fire_s) begin
      commit_pc_d  = pipe_pc;
      commit_cnt_d = commit_cnt_q + 64'd1;
    end else begin
      commit_pc_d  = commit_pc_q;
      commit_cnt_d = commit_cnt_q;
    end
  end

  // Commit trace registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_valid_q <= 1'b0;
      commit_pc_q    <= 64'd0;
      commit_cnt_q   <= 64'd0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_cnt_q   <= commit_cnt_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected register-file
// writes tagged with their cycle; a negedge monitor pops and compares them.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  pipe_valid = 1'b0, pipe_wen = 1'b0;
  logic [REG_ADDR_W-1:0] pipe_rd = 5'd0;
  logic [XLEN-1:0]       pipe_data = 64'd0;
  logic                  lu_issue = 1'b0, lu_valid = 1'b0;
  logic [REG_ADDR_W-1:0] lu_issue_rd = 5'd0, lu_rd = 5'd0;
  logic [XLEN-1:0]       lu_data = 64'd0;
  logic                  pipe_ready, lu_issue_ready, lu_ready, rf_wen;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic [NREG-1:0]       busy_vec;
`ifdef WB_COMMIT_TRACE_EN
  logic [63:0]           pipe_pc = 64'd0;
  logic                  commit_valid;
  logic [63:0]           commit_pc;
`endif

  typedef struct {
    int                    cyc;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  wb_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .pipe_valid     (pipe_valid),
    .pipe_ready     (pipe_ready),
    .pipe_wen       (pipe_wen),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .lu_issue       (lu_issue),
    .lu_issue_rd    (lu_issue_rd),
    .lu_issue_ready (lu_issue_ready),
    .lu_valid       (lu_valid),
    .lu_ready       (lu_ready),
    .lu_rd          (lu_rd),
    .lu_data        (lu_data),
`ifdef WB_COMMIT_TRACE_EN
    .pipe_pc        (pipe_pc),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
`endif
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .busy_vec       (busy_vec)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every rf write must match the oldest expectation for this cycle.
  always @(negedge clock) begin
    if (reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_write cyc=%0d expected addr=%0d data=0x%0h", exp_q[0].cyc, exp_q[0].addr, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (rf_wen) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d actual addr=%0d data=0x%0h", cyc, rf_waddr, rf_wdata);
        end else begin
          if (rf_waddr !== exp_q[0].addr || rf_wdata !== exp_q[0].data) begin
            failures++;
            $display("FAIL write_value cyc=%0d actual addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                     cyc, rf_waddr, rf_wdata, exp_q[0].addr, exp_q[0].data);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_write(input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic set_pipe(input logic v, input logic w, input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    pipe_valid = v;
    pipe_wen   = w;
    pipe_rd    = rd;
    pipe_data  = d;
`ifdef WB_COMMIT_TRACE_EN
    pipe_pc    = 64'h1000 + {59'd0, rd};
`endif
  endtask

  task automatic idle();
    set_pipe(1'b0, 1'b0, 5'd0, 64'd0);
    lu_issue = 1'b0;
    lu_valid = 1'b0;
  endtask

  initial begin
    // Reset state, asserted asynchronously
    #2 reset = 1'b0;
    #1;
    chk("reset_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("reset_rf_wdata", rf_wdata, 64'd0);
    chk("reset_busy", {32'd0, busy_vec}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Plain pipe write rd=5
    set_pipe(1'b1, 1'b1, 5'd5, 64'h1234);
    #1 chk("t1_pipe_ready", {63'd0, pipe_ready}, 64'd1);
    expect_write(5'd5, 64'h1234);
    step();
    idle();
`ifdef WB_COMMIT_TRACE_EN
    chk("t1_commit_valid", {63'd0, commit_valid}, 64'd1);
    chk("t1_commit_pc", commit_pc, 64'h1005);
`endif
    step();

    // Write to x0: handshake completes, nothing is written, port holds
    set_pipe(1'b1, 1'b1, 5'd0, 64'hFFFF);
    #1 chk("t2_pipe_ready", {63'd0, pipe_ready}, 64'd1);
    step();
    idle();
    step();
    chk("t2_hold_waddr", {59'd0, rf_waddr}, 64'd5);
    chk("t2_hold_wdata", rf_wdata, 64'h1234);

    // Long-latency interlock on rd=7
    lu_issue = 1'b1;
    lu_issue_rd = 5'd7;
    #1 chk("t3_issue_ready", {63'd0, lu_issue_ready}, 64'd1);
    step();
    lu_issue = 1'b0;
    chk("t3_busy_set", {32'd0, busy_vec}, 64'h80);
    set_pipe(1'b1, 1'b1, 5'd7, 64'h77);
    #1 chk("t3_pipe_stall", {63'd0, pipe_ready}, 64'd0);
    step();
    chk("t3_pipe_stall2", {63'd0, pipe_ready}, 64'd0);
    lu_valid = 1'b1;
    lu_rd    = 5'd7;
    lu_data  = 64'hAA;
    #1 chk("t3_lu_ready", {63'd0, lu_ready}, 64'd1);
    chk("t3_pipe_stall3", {63'd0, pipe_ready}, 64'd0);
    expect_write(5'd7, 64'hAA);
    step();
    lu_valid = 1'b0;
    #1 chk("t3_busy_clear", {32'd0, busy_vec}, 64'd0);
    chk("t3_pipe_go", {63'd0, pipe_ready}, 64'd1);
    expect_write(5'd7, 64'h77);
    step();
    idle();

    // Simultaneous lu rd=3 and pipe rd=4
    lu_valid = 1'b1;
    lu_rd    = 5'd3;
    lu_data  = 64'h33;
    set_pipe(1'b1, 1'b1, 5'd4, 64'h44);
    #1 chk("t4_pipe_stall", {63'd0, pipe_ready}, 64'd0);
    expect_write(5'd3, 64'h33);
    step();
    lu_valid = 1'b0;
    #1 chk("t4_pipe_go", {63'd0, pipe_ready}, 64'd1);
    expect_write(5'd4, 64'h44);
    step();
    idle();

    // Same-cycle retire and re-issue on rd=9: set wins
    lu_issue = 1'b1;
    lu_issue_rd = 5'd9;
    step();
    lu_issue = 1'b0;
    chk("t5_busy_set", {32'd0, busy_vec}, 64'h200);
    lu_valid = 1'b1;
    lu_rd    = 5'd9;
    lu_data  = 64'h99;
    lu_issue = 1'b1;
    #1 chk("t5_reissue_ready", {63'd0, lu_issue_ready}, 64'd1);
    expect_write(5'd9, 64'h99);
    step();
    lu_valid = 1'b0;
    lu_issue = 1'b0;
    #1 chk("t5_busy_kept", {32'd0, busy_vec}, 64'h200);
    chk("t5_issue_blocked", {63'd0, lu_issue_ready}, 64'd0);
    lu_valid = 1'b1;
    lu_data  = 64'h9A;
    expect_write(5'd9, 64'h9A);
    step();
    idle();
    chk("t5_busy_clear", {32'd0, busy_vec}, 64'd0);
    step();

    // Asynchronous reset mid-operation
    lu_issue = 1'b1;
    lu_issue_rd = 5'd7;
    set_pipe(1'b1, 1'b1, 5'd2, 64'h22);
    step();
    idle();
    chk("t6_pre_wen", {63'd0, rf_wen}, 64'd1);
    chk("t6_pre_waddr", {59'd0, rf_waddr}, 64'd2);
    chk("t6_pre_wdata", rf_wdata, 64'h22);
    chk("t6_pre_busy", {32'd0, busy_vec}, 64'h80);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_wen", {63'd0, rf_wen}, 64'd0);
    chk("t6_rst_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("t6_rst_wdata", rf_wdata, 64'd0);
    chk("t6_rst_busy", {32'd0, busy_vec}, 64'd0);
`ifdef WB_COMMIT_TRACE_EN
    chk("t6_rst_commit_cnt", dut.commit_cnt_q, 64'd0);
    chk("t6_rst_commit_valid", {63'd0, commit_valid}, 64'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
    step();
    step();
    step();
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
